// File: rtl/proc_trace_pkg.sv
// rtl/proc_trace_pkg.sv - shared widths and trace entry layout for the processor trace buffer
//   Purpose : field widths and the packed trace entry used by proc_trace_buffer.
//   Ports   : none (package).
package proc_trace_pkg;

   localparam int PC_W    = 7;
   localparam int IR_W    = 16;
   localparam int ALU_W   = 16;
   localparam int STATE_W = 4;
   localparam int STAMP_W = 8;
   localparam int ENTRY_W = STAMP_W + PC_W + IR_W + ALU_W;

   // Field order fixes the Rd_Data layout: {stamp, pc, ir, alu}, stamp in the MSBs.
   typedef struct packed {
      logic [STAMP_W-1:0] stamp;
      logic [PC_W-1:0]    pc;
      logic [IR_W-1:0]    ir;
      logic [ALU_W-1:0]   alu;
   } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through trace FIFO with drop or overwrite on full
//   Purpose : stores trace entries; never back-pressures the writer.
//   Ports   : i_clk, i_rst (async, active-high)
//             i_push, i_wr_data     - write side, one entry per cycle
//             i_pop_req             - consumer ready; pops only when o_rd_valid
//             o_rd_data, o_rd_valid - head entry, fall-through
//             o_count, o_full       - occupancy
//             o_overflow            - sticky, set when a push meets a full FIFO with no pop
module trace_fifo #(
   parameter int DEPTH   = 16,
   parameter int WRAP    = 0,
   parameter int ENTRY_W = 47
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_wr_data,
   input  logic               i_pop_req,
   output logic [ENTRY_W-1:0] o_rd_data,
   output logic               o_rd_valid,
   output logic [$clog2(DEPTH):0] o_count,
   output logic               o_full,
   output logic               o_overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push_blocked;
   logic w_write;
   logic w_rd_adv;
   logic w_inc;
   logic w_dec;

   assign w_empty        = (r_count == '0);
   assign w_full         = (r_count == CNT_W'(DEPTH));
   assign w_pop          = !w_empty && i_pop_req;
   // A push into a full FIFO with no pop freeing a slot: lost or overwrites the oldest.
   assign w_push_blocked = i_push && w_full && !w_pop;
   assign w_write        = i_push && (!w_push_blocked || (WRAP != 0));
   assign w_rd_adv       = w_pop || (w_push_blocked && (WRAP != 0));
   assign w_inc          = i_push && !w_full && !w_pop;
   assign w_dec          = w_pop && !i_push;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_adv) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_inc)      r_count <= r_count + CNT_W'(1);
         else if (w_dec) r_count <= r_count - CNT_W'(1);
         if (w_push_blocked) r_overflow <= 1'b1;
      end
   end

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_rd_valid = !w_empty;
   assign o_count    = r_count;
   assign o_full     = w_full;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/proc_trace_buffer.sv
// rtl/proc_trace_buffer.sv - timestamped capture of processor state on entry to a trigger state
//   Purpose : watches the processor FSM and queues {stamp, PC, IR, ALU} each time
//             State_In enters TRIG_STATE; entries drain through a valid/ready port.
//   Ports   : Clk, Reset (async, active-high)
//             PC_In, IR_In, State_In, ALU_In - processor observation inputs
//             Capture_En                     - capture gate
//             Rd_Ready, Rd_Valid, Rd_Data    - first-word-fall-through read port
//             Count, Full, Overflow          - FIFO status
module proc_trace_buffer
   import proc_trace_pkg::*;
#(
   parameter int                 DEPTH      = 16,
   parameter logic [STATE_W-1:0] TRIG_STATE = 4'd3,
   parameter int                 WRAP       = 0
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [PC_W-1:0]      PC_In,
   input  logic [IR_W-1:0]      IR_In,
   input  logic [STATE_W-1:0]   State_In,
   input  logic [ALU_W-1:0]     ALU_In,
   input  logic                 Capture_En,
   input  logic                 Rd_Ready,
   output logic                 Rd_Valid,
   output logic [ENTRY_W-1:0]   Rd_Data,
   output logic [$clog2(DEPTH):0] Count,
   output logic                 Full,
   output logic                 Overflow
);

   logic [STAMP_W-1:0] r_stamp;
   logic [STATE_W-1:0] r_prev_state;
   logic               w_trig;
   trace_entry_t       w_entry;

   // prev_state resets to TRIG_STATE so the first cycle after reset cannot look like an entry.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_stamp      <= '0;
         r_prev_state <= TRIG_STATE;
      end else begin
         r_stamp      <= r_stamp + STAMP_W'(1);
         r_prev_state <= State_In;
      end
   end

   assign w_trig  = Capture_En && (State_In == TRIG_STATE) && (r_prev_state != TRIG_STATE);
   assign w_entry = '{stamp: r_stamp, pc: PC_In, ir: IR_In, alu: ALU_In};

   trace_fifo #(
      .DEPTH   (DEPTH),
      .WRAP    (WRAP),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .i_clk      (Clk),
      .i_rst      (Reset),
      .i_push     (w_trig),
      .i_wr_data  (w_entry),
      .i_pop_req  (Rd_Ready),
      .o_rd_data  (Rd_Data),
      .o_rd_valid (Rd_Valid),
      .o_count    (Count),
      .o_full     (Full),
      .o_overflow (Overflow)
   );

endmodule

// File: tb/tb_proc_trace_buffer.sv
// tb/tb_proc_trace_buffer.sv - self-checking bench for proc_trace_buffer (drop and overwrite variants)
module tb_proc_trace_buffer;

   localparam int DEPTH = 16;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [6:0]  PC_In = '0;
   logic [15:0] IR_In = '0;
   logic [3:0]  State_In = '0;
   logic [15:0] ALU_In = '0;
   logic        Capture_En = 1'b1;
   logic        Rd_Ready = 1'b0;

   logic        rv0, rv1, full0, full1, ovf0, ovf1;
   logic [46:0] rd0, rd1;
   logic [4:0]  cnt0, cnt1;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   proc_trace_buffer #(.DEPTH(DEPTH), .TRIG_STATE(4'd3), .WRAP(0)) u_dut0 (
      .Clk(Clk), .Reset(Reset), .PC_In(PC_In), .IR_In(IR_In), .State_In(State_In),
      .ALU_In(ALU_In), .Capture_En(Capture_En), .Rd_Ready(Rd_Ready), .Rd_Valid(rv0),
      .Rd_Data(rd0), .Count(cnt0), .Full(full0), .Overflow(ovf0));

   proc_trace_buffer #(.DEPTH(DEPTH), .TRIG_STATE(4'd3), .WRAP(1)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .PC_In(PC_In), .IR_In(IR_In), .State_In(State_In),
      .ALU_In(ALU_In), .Capture_En(Capture_En), .Rd_Ready(Rd_Ready), .Rd_Valid(rv1),
      .Rd_Data(rd1), .Count(cnt1), .Full(full1), .Overflow(ovf1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: queues of entries, one per variant.
   logic [46:0] q0[$];
   logic [46:0] q1[$];
   logic        m_ovf0, m_ovf1;
   int          m_stamp;
   logic [3:0]  m_prev;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q0.delete(); q1.delete();
         m_ovf0 = 1'b0; m_ovf1 = 1'b0;
         m_stamp = 0; m_prev = 4'd3;
      end else begin
         logic        trig;
         logic [46:0] e;
         bit          pop0, pop1, was_full0, was_full1;
         trig = Capture_En && State_In == 4'd3 && m_prev != 4'd3;
         e = {m_stamp[7:0], PC_In, IR_In, ALU_In};
         pop0 = q0.size() > 0 && Rd_Ready;
         pop1 = q1.size() > 0 && Rd_Ready;
         was_full0 = q0.size() == DEPTH;
         was_full1 = q1.size() == DEPTH;
         if (pop0) void'(q0.pop_front());
         if (pop1) void'(q1.pop_front());
         if (trig) begin
            if (was_full0 && !pop0) m_ovf0 = 1'b1;
            else q0.push_back(e);
            if (was_full1 && !pop1) begin
               m_ovf1 = 1'b1;
               void'(q1.pop_front());
               q1.push_back(e);
            end else q1.push_back(e);
         end
         m_prev = State_In;
         m_stamp = (m_stamp + 1) % 256;
      end
   end

   always @(negedge Clk) begin
      chk("valid0", 64'(rv0), 64'(q0.size() != 0));
      chk("count0", 64'(cnt0), 64'(q0.size()));
      chk("full0", 64'(full0), 64'(q0.size() == DEPTH));
      chk("ovf0", 64'(ovf0), 64'(m_ovf0));
      if (q0.size() != 0) chk("data0", 64'(rd0), 64'(q0[0]));
      chk("valid1", 64'(rv1), 64'(q1.size() != 0));
      chk("count1", 64'(cnt1), 64'(q1.size()));
      chk("full1", 64'(full1), 64'(q1.size() == DEPTH));
      chk("ovf1", 64'(ovf1), 64'(m_ovf1));
      if (q1.size() != 0) chk("data1", 64'(rd1), 64'(q1[0]));
   end

   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      State_In = 4'd0;
      Rd_Ready = 1'b0;
      Capture_En = 1'b1;
   endtask

   task automatic trig_pc(input logic [6:0] pc);
      cyc();
      State_In = 4'd3;
      PC_In = pc;
      IR_In = {9'h0, pc} ^ 16'hA5A5;
      ALU_In = {pc, 9'h1F};
      cyc();
      State_In = 4'd0;
   endtask

   initial begin
      // reset state
      cyc();
      #1;
      chk("rst_valid", 64'(rv0), 64'd0);
      chk("rst_count", 64'(cnt0), 64'd0);
      chk("rst_full", 64'(full0), 64'd0);
      chk("rst_ovf", 64'(ovf0), 64'd0);
      chk("rst_data", 64'(rd0), 64'd0);
      #1;
      // cycle 0 after release: stamp 0, State 0
      Reset = 1'b0;
      State_In = 4'd0;
      // cycle 1: enter state 3, stamp 1
      cyc();
      State_In = 4'd3; PC_In = 7'h05; IR_In = 16'h2104; ALU_In = 16'h0009;
      cyc();
      #1;
      chk("first_valid", 64'(rv0), 64'd1);
      chk("first_count", 64'(cnt0), 64'd1);
      chk("first_data", 64'(rd0), 64'({8'd1, 7'h05, 16'h2104, 16'h0009}));
      // dwell in state 3 through cycle 5, leave in 6, re-enter in 7
      cyc(); cyc(); cyc();
      cyc(); State_In = 4'd2;
      cyc(); State_In = 4'd3; PC_In = 7'h06; IR_In = 16'h1111; ALU_In = 16'h2222;
      cyc(); State_In = 4'd0; Rd_Ready = 1'b1;
      #1;
      chk("dwell_count", 64'(cnt0), 64'd2);
      cyc();
      #1;
      chk("second_data", 64'(rd0), 64'({8'd7, 7'h06, 16'h1111, 16'h2222}));
      chk("stamp_gap", 64'(rd0[46:39] - 8'd1), 64'd6);
      cyc();
      Rd_Ready = 1'b0;
      #1;
      chk("drained", 64'(rv0), 64'd0);

      // full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 16; i++) trig_pc(7'(i));
      cyc();
      State_In = 4'd3; PC_In = 7'd17; Rd_Ready = 1'b1;
      cyc();
      State_In = 4'd0; Rd_Ready = 1'b0;
      #1;
      chk("pp_count0", 64'(cnt0), 64'd16);
      chk("pp_ovf0", 64'(ovf0), 64'd0);
      chk("pp_head0", 64'(rd0[38:32]), 64'd2);
      chk("pp_count1", 64'(cnt1), 64'd16);
      chk("pp_ovf1", 64'(ovf1), 64'd0);
      chk("pp_head1", 64'(rd1[38:32]), 64'd2);

      // 17 triggers, no reads: drop vs overwrite
      do_reset();
      for (int i = 1; i <= 17; i++) trig_pc(7'(i));
      cyc();
      #1;
      chk("of_count0", 64'(cnt0), 64'd16);
      chk("of_full0", 64'(full0), 64'd1);
      chk("of_ovf0", 64'(ovf0), 64'd1);
      chk("of_count1", 64'(cnt1), 64'd16);
      chk("of_ovf1", 64'(ovf1), 64'd1);
      Rd_Ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("drain_pc0", 64'(rd0[38:32]), 64'(i + 1));
         chk("drain_pc1", 64'(rd1[38:32]), 64'(i + 2));
         cyc();
      end
      Rd_Ready = 1'b0;
      #1;
      chk("of_empty0", 64'(rv0), 64'd0);
      chk("of_empty1", 64'(rv1), 64'd0);

      // async reset mid-stream with 5 entries and Overflow still set
      for (int i = 1; i <= 5; i++) trig_pc(7'(i + 40));
      cyc();
      #1;
      chk("pre_rst_count", 64'(cnt0), 64'd5);
      Reset = 1'b1;
      #1;
      chk("arst_valid", 64'(rv0), 64'd0);
      chk("arst_count", 64'(cnt0), 64'd0);
      chk("arst_ovf", 64'(ovf0), 64'd0);
      chk("arst_ovf1", 64'(ovf1), 64'd0);
      cyc();
      // first cycle after reset sitting in state 3 must not capture
      Reset = 1'b0; State_In = 4'd3; Capture_En = 1'b1;
      cyc();
      #1;
      chk("post_rst_nocap", 64'(cnt0), 64'd0);
      State_In = 4'd0;
      cyc();
      State_In = 4'd3; Capture_En = 1'b0;
      cyc();
      Capture_En = 1'b1;
      #1;
      chk("gated_nocap", 64'(cnt0), 64'd0);
      cyc();
      #1;
      chk("dwell_nocap", 64'(cnt0), 64'd0);
      State_In = 4'd0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
